// File: rtl/rv32i_types.sv
// ============================================================================
// Package     : rv32i_types
// Description : Shared types for the RV32I pipeline hazard control.
//               fwd_sel_t  - EX operand source select
//               hz_state_t - hazard controller FSM state
// Revision    : 1.0 - initial parametrised hazard control
// ============================================================================
`default_nettype none

package rv32i_types;

  // Operand source seen by the EX stage ALU
  typedef enum logic [1:0] {
    REGFILE = 2'd0,
    MEM_FWD = 2'd1,
    WB_FWD  = 2'd2
  } fwd_sel_t;

  // RUN : normal operation
  // HOLD: redirect taken while a wrong-path fetch was still outstanding
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_detect.sv
// ============================================================================
// Module      : hazard_fwd_detect
// Description : Combinational register-compare logic. Produces the load-use
//               (or general RAW when forwarding is off) hazard flag and the
//               EX-stage forwarding selects. Register index 0 never matches.
// Ports       : i_id_*   - ID source registers and their use flags
//               i_ex_*   - EX sources, destination, write and load flags
//               i_mem_*  - MEM destination and write flag
//               i_wb_*   - WB destination and write flag
//               o_lu_haz - hazard requiring an ID stall
//               o_fwd_sel1/2 - 0 regfile, 1 MEM alu_out, 2 WB_in
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_detect
  import rv32i_types::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_ex_rs1,
  input  logic [REG_AW-1:0] i_ex_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_ld_reg,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_ld_reg,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_ld_reg,
  output logic              o_lu_haz,
  output logic [1:0]        o_fwd_sel1,
  output logic [1:0]        o_fwd_sel2
);

  // A write to x0 is architecturally discarded, so it can never be a producer.
  function automatic logic f_hit(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] dst,
                                 input logic             wr);
    return wr && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] f_sel(input logic [REG_AW-1:0] src);
    if (f_hit(src, i_mem_rd, i_mem_ld_reg)) return MEM_FWD;   // youngest wins
    if (f_hit(src, i_wb_rd, i_wb_ld_reg))   return WB_FWD;
    return REGFILE;
  endfunction

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = (i_id_use_rs1 && f_hit(i_id_rs1, i_ex_rd, i_ex_ld_reg)) ||
                     (i_id_use_rs2 && f_hit(i_id_rs2, i_ex_rd, i_ex_ld_reg));
  assign w_mem_hit = (i_id_use_rs1 && f_hit(i_id_rs1, i_mem_rd, i_mem_ld_reg)) ||
                     (i_id_use_rs2 && f_hit(i_id_rs2, i_mem_rd, i_mem_ld_reg));

  // With forwarding only a load in EX cannot be bypassed in time. Without
  // forwarding any pending EX/MEM producer stalls; WB is covered by the
  // write-through regfile.
  assign o_lu_haz   = (FWD_EN != 0) ? (i_ex_mem_read && w_ex_hit)
                                    : (w_ex_hit || w_mem_hit);
  assign o_fwd_sel1 = (FWD_EN != 0) ? f_sel(i_ex_rs1) : 2'(REGFILE);
  assign o_fwd_sel2 = (FWD_EN != 0) ? f_sel(i_ex_rs2) : 2'(REGFILE);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : 5-stage RV32I pipe control. Generates PC and pipe register
//               enables, IF/ID flush and ID/EX bubble, EX forwarding selects,
//               handles load-use, EX redirects and redirects that collide
//               with an outstanding I-fetch, and keeps saturating counters.
// Ports       : clk, reset (async, active-high)
//               imem_req/resp, dmem_req/resp - cache handshakes
//               id_*, ex_*, mem_*, wb_*      - per-stage register info
//               pc_load/pc_sel/redirect_pc   - PC control
//               load_*, flush_if_id, bubble_id_ex - pipe register control
//               fwd_sel1/2                   - EX operand select
//               stall_cnt/flush_cnt/loaduse_cnt - performance counters
// Revision    : 1.0 - initial parametrised hazard control
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_req,
  input  logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_ld_reg,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_ld_reg,
  input  logic              wb_ld_reg,
  output logic              pc_load,
  output logic              pc_sel,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              load_if_id,
  output logic              load_id_ex,
  output logic              load_ex_mem,
  output logic              load_mem_wb,
  output logic              flush_if_id,
  output logic              bubble_id_ex,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  loaduse_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_t        r_state;
  hz_state_t        w_next;
  logic [XLEN-1:0]  r_tgt_q;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_loaduse_cnt;

  logic       w_mem_stall;
  logic       w_if_stall;
  logic       w_lu_haz;
  logic [1:0] w_fwd1;
  logic [1:0] w_fwd2;
  logic       w_latch_tgt;
  logic       w_redirect_acc;
  logic       w_loaduse;

  hazard_fwd_detect #(
    .REG_AW (REG_AW),
    .FWD_EN (FWD_EN)
  ) u_detect (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .i_ex_rs1      (ex_rs1),
    .i_ex_rs2      (ex_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_ld_reg   (ex_ld_reg),
    .i_ex_mem_read (ex_mem_read),
    .i_mem_rd      (mem_rd),
    .i_mem_ld_reg  (mem_ld_reg),
    .i_wb_rd       (wb_rd),
    .i_wb_ld_reg   (wb_ld_reg),
    .o_lu_haz      (w_lu_haz),
    .o_fwd_sel1    (w_fwd1),
    .o_fwd_sel2    (w_fwd2)
  );

  assign w_mem_stall = dmem_req & ~dmem_resp;
  assign w_if_stall  = imem_req & ~imem_resp;

  // In HOLD the live ex_target belongs to a bubble, so the latched one is used.
  assign redirect_pc = (r_state == HOLD) ? r_tgt_q : ex_target;
  assign fwd_sel1    = reset ? 2'(REGFILE) : w_fwd1;
  assign fwd_sel2    = reset ? 2'(REGFILE) : w_fwd2;

  always_comb begin
    w_next         = r_state;
    w_latch_tgt    = 1'b0;
    w_redirect_acc = 1'b0;
    w_loaduse      = 1'b0;
    pc_load        = 1'b1;
    pc_sel         = 1'b0;
    load_if_id     = 1'b1;
    load_id_ex     = 1'b1;
    load_ex_mem    = 1'b1;
    load_mem_wb    = 1'b1;
    flush_if_id    = 1'b0;
    bubble_id_ex   = 1'b0;

    if (reset) begin
      pc_load      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (w_mem_stall) begin
      // Whole pipe frozen, FSM included
      pc_load     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (r_state == HOLD) begin
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
      pc_load      = 1'b0;
      // The returning word is wrong-path: drop it and go to the saved target
      if (imem_resp) begin
        pc_load = 1'b1;
        pc_sel  = 1'b1;
        w_next  = RUN;
      end
    end else if (ex_redirect) begin
      load_if_id     = 1'b0;
      load_id_ex     = 1'b0;
      flush_if_id    = 1'b1;
      bubble_id_ex   = 1'b1;
      w_redirect_acc = 1'b1;
      if (w_if_stall) begin
        pc_load     = 1'b0;
        w_latch_tgt = 1'b1;
        w_next      = HOLD;
      end else begin
        pc_sel = 1'b1;
      end
    end else if (w_lu_haz || w_if_stall) begin
      pc_load      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      bubble_id_ex = 1'b1;
      w_loaduse    = w_lu_haz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_tgt_q       <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_loaduse_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch_tgt) r_tgt_q <= ex_target;
      if (!pc_load && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (w_redirect_acc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
      if (w_loaduse && (r_loaduse_cnt != '1))
        r_loaduse_cnt <= r_loaduse_cnt + c_cnt_one;
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign loaduse_cnt = r_loaduse_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Instance a uses
//               forwarding (FWD_EN=1, 32-bit counters); instance b has no
//               forwarding and 3-bit counters to reach saturation quickly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        pc_load;
    logic        pc_sel;
    logic [3:0]  ld;      // {if_id, id_ex, ex_mem, mem_wb}
    logic        flush;
    logic        bubble;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] rpc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req, imem_resp, dmem_req, dmem_resp;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_ld_reg, ex_mem_read, ex_redirect;
  logic        mem_ld_reg, wb_ld_reg;
  logic [31:0] ex_target;

  logic        a_pc_load, a_pc_sel, a_ld_if, a_ld_ex, a_ld_mem, a_ld_wb, a_flush, a_bubble;
  logic [31:0] a_rpc, a_stall_cnt, a_flush_cnt, a_loaduse_cnt;
  logic [1:0]  a_f1, a_f2;
  logic        b_pc_load, b_pc_sel, b_ld_if, b_ld_ex, b_ld_mem, b_ld_wb, b_flush, b_bubble;
  logic [31:0] b_rpc;
  logic [2:0]  b_stall_cnt, b_flush_cnt, b_loaduse_cnt;
  logic [1:0]  b_f1, b_f2;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t e;
  exp_t o;

  pipe_hazard_ctrl #(.XLEN(32), .REG_AW(5), .FWD_EN(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ld_reg(ex_ld_reg),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_ld_reg(mem_ld_reg), .wb_ld_reg(wb_ld_reg),
    .pc_load(a_pc_load), .pc_sel(a_pc_sel), .redirect_pc(a_rpc),
    .load_if_id(a_ld_if), .load_id_ex(a_ld_ex), .load_ex_mem(a_ld_mem), .load_mem_wb(a_ld_wb),
    .flush_if_id(a_flush), .bubble_id_ex(a_bubble), .fwd_sel1(a_f1), .fwd_sel2(a_f2),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .loaduse_cnt(a_loaduse_cnt)
  );

  pipe_hazard_ctrl #(.XLEN(32), .REG_AW(5), .FWD_EN(0), .CNT_W(3)) dut0 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ld_reg(ex_ld_reg),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_ld_reg(mem_ld_reg), .wb_ld_reg(wb_ld_reg),
    .pc_load(b_pc_load), .pc_sel(b_pc_sel), .redirect_pc(b_rpc),
    .load_if_id(b_ld_if), .load_id_ex(b_ld_ex), .load_ex_mem(b_ld_mem), .load_mem_wb(b_ld_wb),
    .flush_if_id(b_flush), .bubble_id_ex(b_bubble), .fwd_sel1(b_f1), .fwd_sel2(b_f2),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .loaduse_cnt(b_loaduse_cnt)
  );

  function automatic exp_t mk(logic pl, logic ps, logic [3:0] ld, logic fl, logic bb,
                              logic [1:0] f1, logic [1:0] f2, logic [31:0] rpc);
    mk = '{pc_load: pl, pc_sel: ps, ld: ld, flush: fl, bubble: bb, f1: f1, f2: f2, rpc: rpc};
  endfunction

  function automatic exp_t obs_a();
    obs_a = mk(a_pc_load, a_pc_sel, {a_ld_if, a_ld_ex, a_ld_mem, a_ld_wb},
               a_flush, a_bubble, a_f1, a_f2, a_rpc);
  endfunction

  function automatic exp_t obs_b();
    obs_b = mk(b_pc_load, b_pc_sel, {b_ld_if, b_ld_ex, b_ld_mem, b_ld_wb},
               b_flush, b_bubble, b_f1, b_f2, b_rpc);
  endfunction

  task automatic idle();
    imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_ld_reg = 0; ex_mem_read = 0;
    ex_redirect = 0; ex_target = 0;
    mem_rd = 0; wb_rd = 0; mem_ld_reg = 0; wb_ld_reg = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_ld_reg = 1; wb_ld_reg = 1;
    ex_target = 32'h24;
    q.push_back(mk(0, 0, 4'b0000, 1, 1, 2'd0, 2'd0, 32'h24));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL reset_outputs obs=%h exp=%h", o, e); end
    n_cmp++;
    if ({a_stall_cnt, a_flush_cnt, a_loaduse_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL reset_counters obs=%0d/%0d/%0d exp=0/0/0", a_stall_cnt, a_flush_cnt, a_loaduse_cnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  task automatic test_loaduse();
    // lw x5 in EX, add reading x5 in ID
    @(negedge clk);
    idle();
    ex_mem_read = 1; ex_ld_reg = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    q.push_back(mk(0, 0, 4'b0011, 0, 1, 2'd0, 2'd0, 32'h0));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL loaduse_stall obs=%h exp=%h", o, e); end
    // bubble in EX, lw in MEM: forwarding design proceeds, the other must stall
    @(negedge clk);
    idle();
    id_rs1 = 5; id_use_rs1 = 1; mem_rd = 5; mem_ld_reg = 1;
    q.push_back(mk(1, 0, 4'b1111, 0, 0, 2'd0, 2'd0, 32'h0));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL loaduse_release obs=%h exp=%h", o, e); end
    n_cmp++;
    if (a_loaduse_cnt !== 32'd1 || a_stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL loaduse_counts obs=%0d/%0d exp=1/1", a_loaduse_cnt, a_stall_cnt);
    end
    // add in EX, lw in WB
    @(negedge clk);
    idle();
    ex_rs1 = 5; wb_rd = 5; wb_ld_reg = 1;
    q.push_back(mk(1, 0, 4'b1111, 0, 0, 2'd2, 2'd0, 32'h0));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL loaduse_wb_fwd obs=%h exp=%h", o, e); end
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    idle();
    ex_rs2 = 7; mem_rd = 7; wb_rd = 7; mem_ld_reg = 1; wb_ld_reg = 1;
    q.push_back(mk(1, 0, 4'b1111, 0, 0, 2'd0, 2'd1, 32'h0));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_mem_over_wb obs=%h exp=%h", o, e); end
    n_cmp++;
    if (b_f2 !== 2'd0) begin n_fail++; $display("FAIL fwd_disabled obs=%0d exp=0", b_f2); end
    @(negedge clk);
    mem_ld_reg = 0;
    q.push_back(mk(1, 0, 4'b1111, 0, 0, 2'd0, 2'd2, 32'h0));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_wb_only obs=%h exp=%h", o, e); end
    @(negedge clk);
    mem_ld_reg = 1; ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
    q.push_back(mk(1, 0, 4'b1111, 0, 0, 2'd0, 2'd0, 32'h0));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_x0 obs=%h exp=%h", o, e); end
  endtask

  task automatic test_redirect_hit();
    // redirect with a simultaneous load-use: redirect wins
    @(negedge clk);
    idle();
    ex_redirect = 1; ex_target = 32'h60; imem_req = 1; imem_resp = 1;
    ex_mem_read = 1; ex_ld_reg = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
    q.push_back(mk(1, 1, 4'b0011, 1, 1, 2'd0, 2'd0, 32'h60));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL redirect_hit obs=%h exp=%h", o, e); end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (a_flush_cnt !== 32'd1 || a_loaduse_cnt !== 32'd1 || a_stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL redirect_hit_counts obs=%0d/%0d/%0d exp=1/1/1", a_flush_cnt, a_loaduse_cnt, a_stall_cnt);
    end
  endtask

  task automatic test_redirect_miss();
    @(negedge clk);
    idle();
    ex_redirect = 1; ex_target = 32'h80; imem_req = 1; imem_resp = 0;
    q.push_back(mk(0, 0, 4'b0011, 1, 1, 2'd0, 2'd0, 32'h80));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL redirect_miss_enter obs=%h exp=%h", o, e); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      // a stray redirect in HOLD must be ignored; live target must not leak out
      ex_redirect = (i == 1); ex_target = 32'h44;
      q.push_back(mk(0, 0, 4'b0011, 1, 1, 2'd0, 2'd0, 32'h80));
      #1;
      e = q.pop_front(); o = obs_a(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL redirect_hold_%0d obs=%h exp=%h", i, o, e); end
    end
    @(negedge clk);
    ex_redirect = 0; imem_resp = 1;
    q.push_back(mk(1, 1, 4'b0011, 1, 1, 2'd0, 2'd0, 32'h80));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL redirect_hold_resp obs=%h exp=%h", o, e); end
    @(negedge clk);
    idle();
    ex_target = 32'h44;
    q.push_back(mk(1, 0, 4'b1111, 0, 0, 2'd0, 2'd0, 32'h44));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL redirect_back_to_run obs=%h exp=%h", o, e); end
    n_cmp++;
    if (a_flush_cnt !== 32'd2 || a_stall_cnt !== 32'd4) begin
      n_fail++; $display("FAIL redirect_miss_counts obs=%0d/%0d exp=2/4", a_flush_cnt, a_stall_cnt);
    end
  endtask

  task automatic test_dmiss_over_hazard();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      dmem_req = 1; dmem_resp = 0;
      ex_mem_read = 1; ex_ld_reg = 1; ex_rd = 6; id_rs1 = 6; id_use_rs1 = 1;
      q.push_back(mk(0, 0, 4'b0000, 0, 0, 2'd0, 2'd0, 32'h0));
      #1;
      e = q.pop_front(); o = obs_a(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL dmiss_freeze_%0d obs=%h exp=%h", i, o, e); end
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (a_stall_cnt !== 32'd8 || a_loaduse_cnt !== 32'd1) begin
      n_fail++; $display("FAIL dmiss_counts obs=%0d/%0d exp=8/1", a_stall_cnt, a_loaduse_cnt);
    end
  endtask

  task automatic test_nofwd_stall();
    @(negedge clk);
    idle();
    id_rs1 = 3; id_use_rs1 = 1; mem_rd = 3; mem_ld_reg = 1;
    q.push_back(mk(0, 0, 4'b0011, 0, 1, 2'd0, 2'd0, 32'h0));
    #1;
    e = q.pop_front(); o = obs_b(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL nofwd_mem_raw obs=%h exp=%h", o, e); end
    n_cmp++;
    if (a_pc_load !== 1'b1) begin n_fail++; $display("FAIL fwd_no_mem_stall obs=%b exp=1", a_pc_load); end
    @(negedge clk);
    mem_ld_reg = 0; wb_rd = 3; wb_ld_reg = 1; ex_rs1 = 3;
    q.push_back(mk(1, 0, 4'b1111, 0, 0, 2'd0, 2'd0, 32'h0));
    #1;
    e = q.pop_front(); o = obs_b(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL nofwd_wb_release obs=%h exp=%h", o, e); end
    n_cmp++;
    if (a_f1 !== 2'd2) begin n_fail++; $display("FAIL fwd_wb_sel obs=%0d exp=2", a_f1); end
  endtask

  task automatic test_reset_in_hold();
    @(negedge clk);
    idle();
    ex_redirect = 1; ex_target = 32'h90; imem_req = 1;
    @(negedge clk);
    ex_redirect = 0; ex_target = 32'h10;
    q.push_back(mk(0, 0, 4'b0011, 1, 1, 2'd0, 2'd0, 32'h90));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL hold_before_reset obs=%h exp=%h", o, e); end
    #1 reset = 1'b1;
    q.push_back(mk(0, 0, 4'b0000, 1, 1, 2'd0, 2'd0, 32'h10));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL reset_in_hold obs=%h exp=%h", o, e); end
    n_cmp++;
    if ({a_stall_cnt, a_flush_cnt, a_loaduse_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL reset_in_hold_counters obs=%0d/%0d/%0d exp=0/0/0", a_stall_cnt, a_flush_cnt, a_loaduse_cnt);
    end
    @(negedge clk);
    reset = 1'b0; imem_req = 0;
    q.push_back(mk(1, 0, 4'b1111, 0, 0, 2'd0, 2'd0, 32'h10));
    #1;
    e = q.pop_front(); o = obs_a(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL run_after_reset obs=%h exp=%h", o, e); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      dmem_req = 1;
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (a_stall_cnt !== 32'd10) begin n_fail++; $display("FAIL stall_count_10 obs=%0d exp=10", a_stall_cnt); end
    n_cmp++;
    if (b_stall_cnt !== 3'd7 || b_flush_cnt !== 3'd0) begin
      n_fail++; $display("FAIL stall_saturate obs=%0d/%0d exp=7/0", b_stall_cnt, b_flush_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_loaduse();
    test_fwd_priority();
    test_redirect_hit();
    test_redirect_miss();
    test_dmiss_over_hazard();
    test_nofwd_stall();
    test_reset_in_hold();
    test_saturate();
    if (q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_leftover obs=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the single-bit freeze-all pipe control of the 5-stage RV32I pipeline.
- Generates per-stage load enables, bubbles and flushes, plus EX-stage forwarding selects.
- Handles load-use interlock, redirect (branch/jump) resolved in EX, and redirects that arrive while a fetch is outstanding.
- Keeps saturating performance counters. Sits beside the IF/ID/EX/MEM/WB pipe registers in the CPU top.

Parameters:
XLEN, 32, data/address width
REG_AW, 5, register index width
FWD_EN, 1, 1 = forwarding and load-use interlock only; 0 = no forwarding, stall on any RAW against EX/MEM
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
imem_req  in  1  I-cache read or write asserted
imem_resp  in  1  I-cache response
dmem_req  in  1  D-cache read or write asserted (MEM stage)
dmem_resp  in  1  D-cache response
id_rs1, id_rs2  in  REG_AW  ID source registers
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  REG_AW  EX source registers
ex_rd  in  REG_AW  EX destination
ex_ld_reg  in  1  EX writes regfile
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX branch taken or jump
ex_target  in  XLEN  redirect address
mem_rd, wb_rd  in  REG_AW  MEM/WB destinations
mem_ld_reg, wb_ld_reg  in  1  MEM/WB write regfile
pc_load  out  1  PC register enable
pc_sel  out  1  0 = PC+4, 1 = redirect_pc
redirect_pc  out  XLEN  live ex_target, or latched target in HOLD
load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  pipe register enables
flush_if_id, bubble_id_ex  out  1  clear IF/ID; load NOP into ID/EX
fwd_sel1, fwd_sel2  out  2  0 = regfile, 1 = MEM alu_out, 2 = WB_in
stall_cnt, flush_cnt, loaduse_cnt  out  CNT_W  performance counters

Behaviour:
- Register state: FSM {RUN, HOLD}, target register tgt_q, counters. All are async-cleared on reset: RUN, tgt_q = 0, counters = 0.
- While reset is high: all load_* = 0, pc_load = 0, flush_if_id = 1, bubble_id_ex = 1, fwd_sel = 0. All outputs are combinational from state and inputs.
- Derived signals: mem_stall = dmem_req & ~dmem_resp; if_stall = imem_req & ~imem_resp. A register index of 0 never matches.
- Hazard detection:
  - FWD_EN=1: lu_haz = ex_mem_read & ex_ld_reg & (id_use_rs1 & id_rs1==ex_rd | id_use_rs2 & id_rs2==ex_rd).
  - FWD_EN=0: lu_haz = RAW of ID sources against EX or MEM destinations. The regfile is write-through, so WB is not checked.
- Priority, highest first:
  1. mem_stall: every load_* = 0, pc_load = 0, no bubble or flush. Nothing counts except stall_cnt.
  2. Redirect in RUN without if_stall: pc_load = 1, pc_sel = 1, flush_if_id = 1, bubble_id_ex = 1, EX/MEM and MEM/WB load. Redirect wins over lu_haz.
  3. Redirect in RUN with if_stall: latch tgt_q <= ex_target and go to HOLD. That cycle: bubble_id_ex = 1, flush_if_id = 1, pc_load = 0, EX/MEM and MEM/WB load.
  4. lu_haz: pc_load = 0, load_if_id = 0, bubble_id_ex = 1, later stages load.
  5. if_stall: pc_load = 0, load_if_id = 0, bubble_id_ex = 1, later stages load.
  6. Otherwise all enables = 1, pc_sel = 0.
- HOLD state:
  - The wrong-path fetch is still outstanding. ID/EX is bubbled every cycle and IF/ID stays flushed.
  - On imem_resp (without mem_stall): discard the word (flush_if_id = 1), pc_load = 1, pc_sel = 1, redirect_pc = tgt_q, go to RUN.
  - A new ex_redirect while in HOLD cannot occur, because EX holds a bubble. If it does occur, it is ignored.
  - mem_stall in HOLD freezes the FSM.
- Forwarding (FWD_EN=1 only, otherwise 0): fwd_selN = 1 if mem_ld_reg & mem_rd==ex_rsN; else 2 if wb_ld_reg & wb_rd==ex_rsN; else 0. MEM has priority over WB.
- Counters saturate at all-ones:
  - stall_cnt: +1 per cycle with pc_load = 0 outside reset.
  - flush_cnt: +1 per redirect accepted, in RUN only.
  - loaduse_cnt: +1 per cycle rule 4 applies.
- Reset mid-HOLD returns to RUN and tgt_q is discarded.

Decomposition:
- rv32i_types gets typedef fwd_sel_t (enum REGFILE, MEM_FWD, WB_FWD) and hz_state_t {RUN, HOLD}.
- One sub-module, hazard_fwd_detect: purely combinational compare logic producing lu_haz, fwd_sel1 and fwd_sel2, parametrised by REG_AW and FWD_EN.

Test Plan:
- Load-use: EX lw x5 (ex_mem_read = 1, ex_rd = 5), ID add using rs1 = 5 -> one cycle with pc_load = 0, load_if_id = 0, bubble_id_ex = 1; loaduse_cnt = 1; next cycle fwd_sel1 = 2 once the lw reaches WB.
- Forwarding priority: mem_rd = wb_rd = ex_rs2 = 7, both ld_reg = 1 -> fwd_sel2 = 1. With ex_rs2 = 0 -> fwd_sel2 = 0.
- Redirect, fetch hit: ex_redirect = 1, ex_target = 0x60, imem_resp = 1 -> pc_sel = 1, redirect_pc = 0x60, flush_if_id = 1, bubble_id_ex = 1; flush_cnt = 1.
- Redirect during I-miss: ex_redirect with target 0x80 while imem_resp = 0 for 3 cycles -> HOLD, pc_load = 0 for those cycles; on the resp cycle pc_load = 1, redirect_pc = 0x80, flush_if_id = 1, then RUN.
- D-miss overlaps hazard: dmem_req = 1, dmem_resp = 0 for 4 cycles with lu_haz = 1 -> all loads 0, stall_cnt += 4, loaduse_cnt unchanged.
- FWD_EN=0 build: ID rs1 = 3, mem_rd = 3, mem_ld_reg = 1 -> stall until MEM moves to WB. Assert reset during HOLD -> state RUN, counters 0.
